// File: rtl/mio_lsu_if.sv
// mio_lsu_if: bundles the CPU request/response handshake and the memory-mapped
// IO bus of the load/store unit.
//   master : CPU/bus environment side (drives requests and bus completions)
//   slave  : load/store unit side (drives responses and bus accesses)
interface mio_lsu_if #(
  parameter int unsigned ADDR_W = 32
) ();
  // CPU request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_len;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // CPU response
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // Memory/IO bus
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wea;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_len, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_rw, mem_addr, mem_wdata, mem_wea
  );

  modport slave (
    input  req_valid, req_we, req_len, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_rw, mem_addr, mem_wdata, mem_wea
  );
endinterface

// File: rtl/mio_lsu.sv
// mio_lsu: single-outstanding load/store unit bridging CPU requests onto a
// handshaked memory/IO bus.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - mio_lsu_if.slave: req_* in, req_ready/stall/rsp_* out, mem_* bus
// Parameters:
//   ADDR_W  - request/bus address width (> 2)
//   TIMEOUT - max BUS cycles waiting for mem_ready (2..256)
// Configuration:
//   MIO_LSU_TIMEOUT_EN - when defined, a BUS access that sees no mem_ready for
//   TIMEOUT cycles completes with rsp_err; otherwise BUS waits indefinitely.
module mio_lsu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  mio_lsu_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StBus, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wea_q, wea_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        len_q, len_d;
  logic [1:0]        off_q, off_d;
  logic              illegal;
  logic              timeout_hit;

  // Request legality: unknown lengths, unsigned/oversized stores, misalignment.
  always_comb begin
    illegal = 1'b0;
    unique case (bus.req_len)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = bus.req_addr[0];
      3'b010:         illegal = (bus.req_addr[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
    if (bus.req_we && bus.req_len[2]) illegal = 1'b1;
  end

`ifdef MIO_LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // IDLE always precedes BUS, so clearing there clears on BUS entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StBus && !bus.mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    wea_d   = wea_q;
    rdata_d = rdata_q;
    len_d   = len_q;
    off_d   = off_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          len_d = bus.req_len;
          off_d = bus.req_addr[1:0];
          if (illegal) begin
            state_d = StErr;
          end else begin
            state_d = StBus;
            addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            rw_d    = bus.req_we;
            wea_d   = 4'b0000;
            wdata_d = 32'h0;
            if (bus.req_we) begin
              unique case (bus.req_len[1:0])
                2'b00: begin
                  wea_d   = 4'b0001 << bus.req_addr[1:0];
                  wdata_d = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                  wea_d   = 4'b0011 << bus.req_addr[1:0];
                  wdata_d = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                  wea_d   = 4'b1111;
                  wdata_d = bus.req_wdata;
                end
              endcase
            end
          end
        end
      end
      StBus: begin
        // mem_ready wins over a timeout in the same cycle.
        if (bus.mem_ready) begin
          rdata_d = bus.mem_rdata;
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= 32'h0;
      wea_q   <= 4'b0000;
      rdata_q <= 32'h0;
      len_q   <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      wea_q   <= wea_d;
      rdata_q <= rdata_d;
      len_q   <= len_d;
      off_q   <= off_d;
    end
  end

  // Load data alignment and extension from the captured bus word.
  logic [31:0] lane;
  logic [31:0] load_data;

  always_comb begin
    lane      = rdata_q >> {off_q, 3'b000};
    load_data = lane;
    unique case (len_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.stall     = (state_q == StBus);
  assign bus.mem_req   = (state_q == StBus);
  assign bus.mem_rw    = rw_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wea   = wea_q;
  assign bus.rsp_valid = (state_q == StDone) || (state_q == StErr);
  assign bus.rsp_err   = (state_q == StErr);
  assign bus.rsp_rdata = (state_q == StDone && !rw_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_mio_lsu.sv
module tb_mio_lsu;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  mio_lsu_if #(.ADDR_W(AW)) bus ();

  mio_lsu #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: legality from access size and alignment.
  function automatic bit m_illegal(input bit we, input int len, input logic [31:0] addr);
    int size;
    if (we && !(len == 0 || len == 1 || len == 2)) return 1'b1;
    if (!we && !(len == 0 || len == 1 || len == 2 || len == 4 || len == 5)) return 1'b1;
    size = 1 << (len % 4);
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] m_load(input int len, input logic [31:0] addr,
                                         input logic [31:0] word);
    longint v;
    int b;
    b = addr % 4;
    case (len)
      0, 4: begin
        v = (word >> (8 * b)) % 256;
        if (len == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = (word >> (8 * b)) % 65536;
        if (len == 1 && v >= 32768) v = v - 65536;
      end
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wea(input bit we, input int len, input logic [31:0] addr);
    if (!we) return 0;
    if (len == 0) return 32'(1 << (addr % 4));
    if (len == 1) return 32'(3 << (addr % 4));
    return 15;
  endfunction

  function automatic logic [31:0] m_wdata(input int len, input logic [31:0] d);
    if (len == 0) return (d % 256) * 32'h0101_0101;
    if (len == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // One full transaction; delay = BUS cycles with mem_ready low before completion.
  task automatic xact(input string tag, input bit we, input int len, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] word, input int delay);
    logic [31:0] e_addr;
    chk({tag, ".ready"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_len   = 3'(len);
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    if (m_illegal(we, len, addr)) begin
      chk({tag, ".err_valid"}, 32'(bus.rsp_valid), 1);
      chk({tag, ".err_flag"}, 32'(bus.rsp_err), 1);
      chk({tag, ".err_rdata"}, bus.rsp_rdata, 0);
      chk({tag, ".err_noreq"}, 32'(bus.mem_req), 0);
      step();
      chk({tag, ".err_done"}, 32'(bus.rsp_valid), 0);
      return;
    end
    e_addr = addr - (addr % 4);
    for (int i = 0; i <= delay; i++) begin
      chk({tag, ".stall"}, 32'(bus.stall), 1);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 1);
      chk({tag, ".addr"}, bus.mem_addr, e_addr);
      chk({tag, ".rw"}, 32'(bus.mem_rw), 32'(we));
      chk({tag, ".wea"}, 32'(bus.mem_wea), m_wea(we, len, addr));
      if (we) chk({tag, ".wdata"}, bus.mem_wdata, m_wdata(len, wdata));
      if (i == delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = word;
      end
      step();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
    end
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 0);
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, we ? 32'h0 : m_load(len, addr, word));
    chk({tag, ".released"}, 32'(bus.mem_req), 0);
    step();
    chk({tag, ".pulse"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_len   = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    rst = 1'b0;
    step();
    step();
    chk("rst.req_ready", 32'(bus.req_ready), 1);
    chk("rst.stall", 32'(bus.stall), 0);
    chk("rst.mem_req", 32'(bus.mem_req), 0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst.mem_wea", 32'(bus.mem_wea), 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    rst = 1'b1;
    step();

    xact("sw", 1, 2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    xact("sb", 1, 0, 32'h203, 32'h0000_00A5, 32'h0, 0);
    xact("lb", 0, 0, 32'h11, 32'h0, 32'h1234_8000, 1);
    xact("lbu", 0, 4, 32'h11, 32'h0, 32'h1234_8000, 2);
    xact("lw_mis", 0, 2, 32'h102, 32'h0, 32'h0, 0);
    xact("lh_hi", 0, 1, 32'h3E, 32'h0, 32'h8001_7FFF, TO - 1);
    xact("sh_mis", 1, 1, 32'h41, 32'h1234, 32'h0, 0);
    xact("len7", 0, 7, 32'h40, 32'h0, 32'h0, 0);

    // Wait with mem_ready held low.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_len   = 3'b010;
    bus.req_addr  = 32'h400;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.stall && n < 20) begin
      n++;
      step();
    end
`ifdef MIO_LSU_TIMEOUT_EN
    chk("to.stall_cycles", n, TO);
    chk("to.rsp_valid", 32'(bus.rsp_valid), 1);
    chk("to.rsp_err", 32'(bus.rsp_err), 1);
    chk("to.rsp_rdata", bus.rsp_rdata, 0);
    step();
`else
    chk("to.stall_cycles", n, 20);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_ready = 1'b0;
    chk("to.rsp_valid", 32'(bus.rsp_valid), 1);
    chk("to.rsp_err", 32'(bus.rsp_err), 0);
    chk("to.rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    step();
`endif

    // Reset while a bus access is pending.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_len   = 3'b010;
    bus.req_addr  = 32'h800;
    bus.req_wdata = 32'h5555_AAAA;
    step();
    bus.req_valid = 1'b0;
    chk("mid.in_bus", 32'(bus.mem_req), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid.mem_req", 32'(bus.mem_req), 0);
    chk("mid.req_ready", 32'(bus.req_ready), 1);
    chk("mid.stall", 32'(bus.stall), 0);
    chk("mid.mem_wea", 32'(bus.mem_wea), 0);
    chk("mid.mem_wdata", bus.mem_wdata, 0);
    chk("mid.mem_rw", 32'(bus.mem_rw), 0);
    n = 0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) n++;
      step();
    end
    bus.mem_ready = 1'b0;
    chk("mid.no_rsp", n, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      bit we;
      int len;
      we  = 1'($urandom_range(1, 0));
      len = $urandom_range(7, 0);
      if ($urandom_range(3, 0) != 0) begin
        // Bias toward legal lengths.
        len = we ? $urandom_range(2, 0) : (($urandom_range(1, 0) == 1) ? 4 : 0)
                                          + $urandom_range(1, 0);
        if (!we && $urandom_range(4, 0) == 0) len = 2;
      end
      xact("rand", we, len, $urandom, $urandom, $urandom, $urandom_range(TO - 1, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
